// File: rtl/main_memory_banked_if.sv
// main_memory_banked_if
//   Request/response bus between the core's fetch/load-store stage and the
//   banked main memory. Only one request is outstanding at a time.
//   master : memread, memwrite, address, byte_en, data_in -> memory
//   slave  : busy, resp_valid, data_out, err              -> requester
interface main_memory_banked_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
) ();
  logic                  memread;
  logic                  memwrite;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     data_in;
  logic                  busy;
  logic                  resp_valid;
  logic [DATA_W-1:0]     data_out;
  logic                  err;

  modport master (
    output memread, memwrite, address, byte_en, data_in,
    input  busy, resp_valid, data_out, err
  );

  modport slave (
    input  memread, memwrite, address, byte_en, data_in,
    output busy, resp_valid, data_out, err
  );
endinterface

// File: rtl/main_memory_banked.sv
// main_memory_banked
//   Clocked unified instruction/data memory with a request/response
//   handshake, programmable latency, byte-lane writes and error reporting
//   for misaligned, out-of-range and read+write-conflict requests.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (array contents are not cleared)
//   bus    : main_memory_banked_if.slave (request in, busy/response out)
module main_memory_banked #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 17,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input logic                 clk,
  input logic                 rst_n,
  main_memory_banked_if.slave bus
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   mem_idx_q, mem_idx_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                bad_q, bad_d;
  logic [DATA_W-1:0]   rdata_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                exec;
  logic                misaligned;
  logic                out_of_range;
  logic [IDX_W-1:0]    req_idx;

  if (OFF_W > 0) begin : g_align
    assign misaligned = |bus.address[OFF_W-1:0];
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end

  assign req_idx      = bus.address[ADDR_W-1:OFF_W];
  assign out_of_range = ({1'b0, req_idx} >= (IDX_W+1)'(DEPTH));

  // A request is taken in IDLE and also in RESP, which gives back-to-back
  // accesses without an idle bubble.
  assign accept = (state_q != S_WAIT) && (bus.memread || bus.memwrite);
  // The access itself happens on the edge that leaves WAIT.
  assign exec   = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // State and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      mem_idx_q <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_idx_q <= mem_idx_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      bad_q     <= bad_d;
    end
  end

  // Next-state and request capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_idx_d = mem_idx_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    bad_d     = bad_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d   = S_WAIT;
          cnt_d     = 4'(LATENCY - 1);
          mem_idx_d = req_idx[MEM_AW-1:0];
          be_d      = bus.byte_en;
          wdata_d   = bus.data_in;
          rd_d      = bus.memread;
          wr_d      = bus.memwrite;
          // Error is decided at acceptance so the access edge only has to gate on it.
          bad_d     = misaligned || out_of_range || (bus.memread && bus.memwrite);
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy       = (state_q == S_WAIT);
    bus.resp_valid = (state_q == S_RESP);
    bus.err        = (state_q == S_RESP) && bad_q;
    bus.data_out   = ((state_q == S_RESP) && rd_q && !bad_q) ? rdata_q : '0;
  end

  // Array port: registered read, byte-lane write, no reset so the
  // contents survive rst_n.
  always_ff @(posedge clk) begin
    if (exec) begin
      rdata_q <= mem[mem_idx_q];
      if (wr_q && !bad_q) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be_q[i]) mem[mem_idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_main_memory_banked.sv
module tb_main_memory_banked;
  localparam int DW    = 32;
  localparam int AW    = 17;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  main_memory_banked_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  main_memory_banked_if #(.DATA_W(DW), .ADDR_W(AW)) bus_l1 ();
  main_memory_banked_if #(.DATA_W(DW), .ADDR_W(AW)) bus_l15 ();

  main_memory_banked #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(LAT), .INIT_FILE(""))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  main_memory_banked #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(1), .INIT_FILE(""))
    dut_l1 (.clk(clk), .rst_n(rst_n), .bus(bus_l1));
  main_memory_banked #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(15), .INIT_FILE(""))
    dut_l15 (.clk(clk), .rst_n(rst_n), .bus(bus_l15));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          n_resp = 0;
  int          r1[$];
  int          r15[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response strobe is matched against the oldest expectation.
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      n_resp++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data=%h err=%b expected no response", bus.data_out, bus.err);
      end else begin
        e_mon = sb.pop_front();
        $display("resp %0d: cycle=%0d data=%h err=%b", n_resp, cyc, bus.data_out, bus.err);
        check("resp_data", bus.data_out, e_mon.data);
        check("resp_err", {31'b0, bus.err}, {31'b0, e_mon.err});
        check("resp_cycle", cyc, e_mon.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_l1.resp_valid)  r1.push_back(cyc);
    if (rst_n && bus_l15.resp_valid) r15.push_back(cyc);
  end

  // Issue one request at a negedge where the memory is not busy, predict its
  // response from the reference model, then drive junk while busy.
  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
    int   guard;
    int   w;
    logic bad;
    exp_t e;
    guard = 0;
    while (bus.busy && guard < 50) begin @(negedge clk); guard++; end
    if (bus.busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0");
    end
    w      = int'(addr) / 4;
    bad    = (addr[1:0] != 2'b00) || (w >= DEPTH) || (rd && wr);
    e.err  = bad;
    e.data = 32'h0;
    e.cyc  = cyc + 1 + LAT;
    if (!bad && wr)
      for (int i = 0; i < 4; i++) if (be[i]) model[w][i*8 +: 8] = data[i*8 +: 8];
    if (!bad && rd) e.data = model[w];
    sb.push_back(e);
    bus.memread  = rd;
    bus.memwrite = wr;
    bus.address  = addr;
    bus.byte_en  = be;
    bus.data_in  = data;
    @(posedge clk);
    @(negedge clk);
    guard = 0;
    while (bus.busy && guard < 50) begin
      bus.memread  = 1'($urandom);
      bus.memwrite = 1'($urandom);
      bus.address  = AW'($urandom_range(0, 15) * 4);
      bus.byte_en  = 4'($urandom);
      bus.data_in  = $urandom;
      @(negedge clk);
      guard++;
    end
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int k;
    logic [AW-1:0] a;
    logic          rd;
    logic          wr;

    rst_n = 1'b0;
    bus.memread = 0; bus.memwrite = 0; bus.address = '0; bus.byte_en = '0; bus.data_in = '0;
    bus_l1.memread = 0; bus_l1.memwrite = 0; bus_l1.address = '0; bus_l1.byte_en = '0; bus_l1.data_in = '0;
    bus_l15.memread = 0; bus_l15.memwrite = 0; bus_l15.address = '0; bus_l15.byte_en = '0; bus_l15.data_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    check("reset_data_out", bus.data_out, 32'h0);
    check("reset_err", {31'b0, bus.err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Held read requests: response spacing of LATENCY+1 for LATENCY=1 and 15.
    s = cyc;
    bus_l1.memread = 1'b1;
    bus_l15.memread = 1'b1;
    repeat (70) @(negedge clk);
    bus_l1.memread = 1'b0;
    bus_l15.memread = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("lat1_resp_cycle", (r1.size() > i) ? r1[i] : -1, s + 2 + i * 2);
      check("lat15_resp_cycle", (r15.size() > i) ? r15[i] : -1, s + 16 + i * 16);
    end

    // Give the words used by the random phase a known value.
    for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, AW'(i * 4), 4'hF, $urandom);

    // Byte-lane merge.
    issue(1'b0, 1'b1, 17'h100, 4'b1111, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 17'h100, 4'b0001, 32'h000000AA);
    issue(1'b1, 1'b0, 17'h100, 4'b0000, 32'h0);
    check("byte_lane_model", model[64], 32'hDEADBEAA);

    // Misaligned read, out-of-range write, then confirm nothing was disturbed.
    issue(1'b1, 1'b0, 17'h102, 4'b0000, 32'h0);
    issue(1'b0, 1'b1, AW'(DEPTH * 4), 4'hF, 32'h55555555);
    issue(1'b1, 1'b0, 17'h100, 4'b0000, 32'h0);
    issue(1'b1, 1'b0, 17'h000, 4'b0000, 32'h0);

    // Read+write conflict must not write.
    issue(1'b1, 1'b1, 17'h010, 4'hF, 32'hFFFFFFFF);
    issue(1'b1, 1'b0, 17'h010, 4'b0000, 32'h0);

    // Random traffic, back-to-back.
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 9);
      a  = AW'($urandom_range(0, 15) * 4);
      rd = 1'($urandom);
      wr = !rd;
      if (k == 0) a = a | AW'($urandom_range(1, 3));
      else if (k == 1) a = AW'(DEPTH * 4 + $urandom_range(0, 255) * 4);
      else if (k == 2) begin rd = 1'b1; wr = 1'b1; end
      issue(rd, wr, a, 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset in the middle of a write to 0x20: no response, old data kept.
    while (bus.busy) @(negedge clk);
    bus.memwrite = 1'b1; bus.address = 17'h020; bus.byte_en = 4'hF; bus.data_in = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.memwrite = 1'b0;
    check("wait_busy", {31'b0, bus.busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(1'b1, 1'b0, 17'h020, 4'b0000, 32'h0);

    repeat (10) @(negedge clk);
    check("pending_expectations", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
